// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
    localparam int Q_DEPTH = 2;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);
endpackage

// File: rtl/fetch_out_queue.sv
// fetch_out_queue: 2-entry {pc, instr} FIFO; entry 0 is the head, flush beats push
module fetch_out_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr
);
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [DATA_W-1:0] in0_q, in0_d, in1_q, in1_d;
    logic [CNT_W-1:0]  count_q, count_d, rem;
    // shift out the head on pop, then append a pushed word behind what remains
    always_comb begin
        rem = count_q - CNT_W'(pop);
        pc0_d = pop ? pc1_q : pc0_q;
        in0_d = pop ? in1_q : in0_q;
        pc1_d = pc1_q;
        in1_d = in1_q;
        if (push && rem == CNT_W'(0)) begin
            pc0_d = push_pc;
            in0_d = push_instr;
        end
        if (push && rem == CNT_W'(1)) begin
            pc1_d = push_pc;
            in1_d = push_instr;
        end
        count_d = flush ? CNT_W'(0) : rem + CNT_W'(push);
    end
    // storage and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc0_q   <= '0;
            pc1_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            count_q <= '0;
        end else begin
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            count_q <= count_d;
        end
    end
    assign count      = count_q;
    assign head_pc    = pc0_q;
    assign head_instr = in0_q;
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: drives a 1-cycle-latency imem, tracks the live fetch, queues words for decode
module instruction_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    occ;
    logic              pop, push, issue;
    // issue only when the queue can absorb every word already owed to it
    always_comb begin
        imem_addr     = redirect_valid ? redirect_pc : pc_q;
        pop           = out_valid && out_ready;
        occ           = (CNT_W+1)'(q_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue         = state_q == RUN && !halt && occ < (CNT_W+1)'(Q_DEPTH);
        pc_d          = imem_addr + ADDR_W'(issue);
        inflight_d    = issue;
        inflight_pc_d = issue ? imem_addr : inflight_pc_q;
        push          = inflight_q && !redirect_valid;
        state_d       = state_q;
        if (state_q == IDLE && start)
            state_d = RUN;
        else if (state_q == RUN && halt)
            state_d = DRAIN;
        else if (state_q == DRAIN && !inflight_q && q_count == '0)
            state_d = IDLE;
    end
    // control state, pc and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end
    fetch_out_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_instr),
        .count      (q_count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );
    assign out_valid = q_count != '0;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: directed table, hand sequences and random run against a queue-based model
module tb_instruction_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, halt, redirect_valid, out_ready, out_valid, busy;
    logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
    logic [31:0] mem [256];
    int          n_vec = 0, n_err = 0;

    typedef struct {
        bit          s, h, r;
        logic [31:0] rp;
        bit          ev;
        logic [31:0] epc;
        bit          eb;
        logic [31:0] ea;
    } vec_t;
    vec_t tbl [24];
    vec_t none;

    logic [31:0] mq [$];
    logic [31:0] m_pc, m_inf_pc;
    bit          m_inf;
    int          m_mode;

    always #5 clk = ~clk;
    always @(posedge clk) imem_instr <= mem[imem_addr[7:0]];

    instruction_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .busy(busy)
    );

    function automatic vec_t v(bit s, bit h, bit r, logic [31:0] rp, bit ev, logic [31:0] epc, bit eb, logic [31:0] ea);
        vec_t t;
        t.s = s; t.h = h; t.r = r; t.rp = rp; t.ev = ev; t.epc = epc; t.eb = eb; t.ea = ea;
        return t;
    endfunction

    function automatic logic [31:0] mem_of(logic [31:0] a);
        return mem[a[7:0]];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'd0; m_inf = 0; m_inf_pc = 32'd0; m_mode = 0;
    endtask

    task automatic step(input bit use_t, input vec_t t);
        logic [31:0] addr;
        int qn;
        bit pop, iss;
        @(negedge clk);
        addr = redirect_valid ? redirect_pc : m_pc;
        if (use_t) begin
            chk("tbl_valid", out_valid, t.ev);
            chk("tbl_busy", busy, t.eb);
            chk("tbl_addr", imem_addr, t.ea);
            if (t.ev) begin
                chk("tbl_pc", out_pc, t.epc);
                chk("tbl_instr", out_instr, t.epc + 32'd100);
            end
        end
        qn = mq.size();
        chk("valid", out_valid, qn != 0);
        if (qn != 0) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_instr", out_instr, mem_of(mq[0]));
        end
        chk("busy", busy, m_mode != 0);
        chk("imem_addr", imem_addr, addr);
        pop = qn != 0 && out_ready;
        iss = m_mode == 1 && !halt && (qn - int'(pop) + int'(m_inf)) < 2;
        if (pop) void'(mq.pop_front());
        if (redirect_valid) mq.delete();
        else if (m_inf) mq.push_back(m_inf_pc);
        if (m_mode == 0 && start) m_mode = 1;
        else if (m_mode == 1 && halt) m_mode = 2;
        else if (m_mode == 2 && !m_inf && qn == 0) m_mode = 0;
        m_pc = addr + (iss ? 32'd1 : 32'd0);
        m_inf = iss;
        m_inf_pc = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit s, bit h, bit r, logic [31:0] rp, bit rdy);
        start = s; halt = h; redirect_valid = r; redirect_pc = rp; out_ready = rdy;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) + 32'd100;
        none = v(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = v(1, 0, 0, 0,  0, 0,  0, 0);
        tbl[1]  = v(0, 0, 0, 0,  0, 0,  1, 0);
        tbl[2]  = v(0, 0, 0, 0,  0, 0,  1, 1);
        tbl[3]  = v(0, 0, 0, 0,  1, 0,  1, 2);
        tbl[4]  = v(0, 0, 0, 0,  1, 1,  1, 3);
        tbl[5]  = v(0, 0, 1, 9,  1, 2,  1, 9);
        tbl[6]  = v(0, 0, 0, 0,  0, 0,  1, 10);
        tbl[7]  = v(0, 0, 0, 0,  1, 9,  1, 11);
        tbl[8]  = v(0, 0, 0, 0,  1, 10, 1, 12);
        tbl[9]  = v(0, 0, 0, 0,  1, 11, 1, 13);
        tbl[10] = v(0, 1, 0, 0,  1, 12, 1, 14);
        tbl[11] = v(0, 0, 0, 0,  1, 13, 1, 14);
        tbl[12] = v(0, 0, 0, 0,  0, 0,  1, 14);
        tbl[13] = v(1, 0, 0, 0,  0, 0,  0, 14);
        tbl[14] = v(0, 0, 0, 0,  0, 0,  1, 14);
        tbl[15] = v(0, 0, 0, 0,  0, 0,  1, 15);
        tbl[16] = v(0, 0, 0, 0,  1, 14, 1, 16);
        tbl[17] = v(0, 1, 1, 20, 1, 15, 1, 20);
        tbl[18] = v(0, 0, 0, 0,  0, 0,  1, 20);
        tbl[19] = v(1, 0, 0, 0,  0, 0,  0, 20);
        tbl[20] = v(0, 0, 0, 0,  0, 0,  1, 20);
        tbl[21] = v(0, 0, 0, 0,  0, 0,  1, 21);
        tbl[22] = v(0, 0, 0, 0,  1, 20, 1, 22);
        tbl[23] = v(0, 0, 0, 0,  1, 21, 1, 23);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", imem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency, redirect squash, halt drain/resume, halt+redirect
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].h, tbl[i].r, tbl[i].rp, 1);
            step(1, tbl[i]);
        end

        // backpressure: head and fetch address hold while decode stalls
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0);
            chk("stall_head", out_pc, 22);
            chk("stall_addr", imem_addr, 24);
            step(0, none);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1);
            chk("resume_pc", out_pc, 32'(22 + k));
            step(0, none);
        end

        // asynchronous reset with a full queue
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            step(0, none);
        end
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_instr", out_instr, 0);
        chk("arst_addr", imem_addr, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 1);
        step(0, none);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1);
            step(0, none);
        end
        chk("restart_valid", out_valid, 1);
        chk("restart_pc", out_pc, 0);

        // random control, redirects (including near-wrap targets) and backpressure
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 300));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, rp,
                  $urandom_range(0, 9) < 7);
            step(0, none);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
